fsm: RTL and testbench
======================

// Module: fsm
// PURPOSE
//  Vehicle drive-mode controller: one Moore state machine that turns a speed
//  measurement and an obstacle flag into accelerate/brake commands.
//  It sits between the speed sensor interface and the actuator drivers.
//  All decisions are taken on the rising clock edge; outputs decode the
//  registered state only.
// PARAMETERS
//  SPEED_W    8   width of the unsigned speed input
//  START_SPD  10  speed at or above which START advances to DRIVE
//  MOTION_SPD 30  speed at or above which DRIVE advances to MOTION
//  DRIVE_SPD  20  speed below which MOTION falls back to DRIVE (hysteresis)
//  PARK_HOLD  4   consecutive zero-speed cycles in PARKING before IDLE
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  speed       in   SPEED_W  current vehicle speed, unsigned
//  obstacle    in   1        obstacle detected (level)
//  accelerate  out  1        accelerate command
//  brake       out  1        brake command
// BEHAVIOUR
//  - States: IDLE, START, DRIVE, MOTION, EMERGENCY, PARKING.
//  - reset=1 at posedge: state<=IDLE, park counter<=0.
//    Reset has priority over all inputs and is honoured mid-operation.
//  - Outputs are a pure decode of the state register (1-cycle latency from input):
//    IDLE 0/0, START 1/0, DRIVE 1/0, MOTION 0/0 (cruise), EMERGENCY 0/1,
//    PARKING 0/1 (accelerate/brake).
//    accelerate and brake are never both 1.
//  - After reset: accelerate=0, brake=0.
//  - Transitions, evaluated every posedge, highest priority first:
//    - obstacle=1 in START, DRIVE or MOTION -> EMERGENCY.
//    - IDLE: obstacle=1 -> stay; else speed!=0 -> START.
//    - START: speed==0 -> IDLE; speed>=START_SPD -> DRIVE.
//    - DRIVE: speed==0 -> PARKING; speed>=MOTION_SPD -> MOTION.
//    - MOTION: speed<DRIVE_SPD -> DRIVE. Never goes straight to PARKING or IDLE.
//    - EMERGENCY: obstacle=1 -> stay; else speed==0 -> IDLE, otherwise START.
//    - PARKING: speed!=0 -> START with counter cleared. Otherwise counter
//      increments; when it reaches PARK_HOLD-1, -> IDLE with counter cleared.
//    - All other cases hold state.
//  - Park counter: $clog2(PARK_HOLD)+1 bits; cleared in every state except PARKING.
//  - Speed comparisons are unsigned and full width; speed is never truncated.
//  - Illegal or unused state encodings recover to IDLE on the next edge.
// STRUCTURE
//  - Package fsm_pkg: state_t enum (3-bit) and default threshold constants.
//  - Single module: state register, next-state case block, park counter,
//    output decode. No sub-module needed.
// TESTING
//  - reset=1 for 1 cycle, then speed=0, obstacle=0
//    -> IDLE, accelerate=0, brake=0.
//  - speed=5 -> START (acc=1).
//    speed=12 -> DRIVE (acc=1).
//    speed=35 -> MOTION (acc=0, brk=0).
//    speed=15 -> DRIVE.
//  - In DRIVE, obstacle=1 -> EMERGENCY (brk=1), held while obstacle=1.
//    obstacle=0 with speed=9 -> START; with speed=0 -> IDLE.
//  - In DRIVE, speed=0 -> PARKING (brk=1).
//    Zero held 4 cycles -> IDLE.
//    speed=5 before then -> START, counter cleared.
//  - In IDLE, obstacle=1 with speed=25 -> stays IDLE, outputs 0/0.
//  - reset=1 while in MOTION -> IDLE on that edge, outputs 0/0.
//    Every cycle of every test checks that accelerate and brake are never both 1.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types and default thresholds for the vehicle drive-mode controller.
// The state encoding and the state-to-command decode both live here.
package fsm_pkg;

  localparam int unsigned DEF_SPEED_W    = 8;
  localparam int unsigned DEF_START_SPD  = 10;
  localparam int unsigned DEF_MOTION_SPD = 30;
  localparam int unsigned DEF_DRIVE_SPD  = 20;
  localparam int unsigned DEF_PARK_HOLD  = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DRIVE     = 3'd2,
    MOTION    = 3'd3,
    EMERGENCY = 3'd4,
    PARKING   = 3'd5
  } state_t;

  typedef struct packed {
    logic accelerate;
    logic brake;
  } cmd_t;

  // Moore decode: accelerate and brake are never asserted together.
  function automatic cmd_t state_cmd(state_t s);
    cmd_t c;
    c = '{accelerate: 1'b0, brake: 1'b0};
    case (s)
      START, DRIVE:       c.accelerate = 1'b1;
      EMERGENCY, PARKING: c.brake      = 1'b1;
      default:            c = '{accelerate: 1'b0, brake: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fsm_if.sv
// Sensor-in / actuator-out bundle of the drive-mode controller.
// The master side produces speed/obstacle; the slave side (controller) returns commands.
interface fsm_if
  import fsm_pkg::*;
#(
  parameter int unsigned SPEED_W = DEF_SPEED_W
);

  logic [SPEED_W-1:0] speed;
  logic               obstacle;
  logic               accelerate;
  logic               brake;

  modport master (output speed, obstacle, input accelerate, brake);
  modport slave  (input speed, obstacle, output accelerate, brake);

endinterface

// File: rtl/fsm.sv
// Drive-mode controller: Moore FSM turning speed and obstacle into
// accelerate/brake commands, with hysteresis and a parking hold timer.
module fsm
  import fsm_pkg::*;
#(
  parameter int unsigned SPEED_W    = DEF_SPEED_W,
  parameter int unsigned START_SPD  = DEF_START_SPD,
  parameter int unsigned MOTION_SPD = DEF_MOTION_SPD,
  parameter int unsigned DRIVE_SPD  = DEF_DRIVE_SPD,
  parameter int unsigned PARK_HOLD  = DEF_PARK_HOLD
) (
  input  logic  clk,
  input  logic  reset,
  fsm_if.slave  bus
);

  localparam int unsigned          CNT_W    = $clog2(PARK_HOLD) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(PARK_HOLD - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   park_cnt, park_cnt_nxt;
  logic [SPEED_W-1:0] speed_in;
  logic [31:0]        spd;
  logic               spd_zero;
  cmd_t               cmd;

  // Thresholds are compared against the zero-extended speed, never a truncated one.
  assign speed_in = bus.speed;
  assign spd      = 32'(speed_in);
  assign spd_zero = (speed_in == '0);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so both registers update from pre-edge values.
    if (reset) begin
      state    <= IDLE;
      park_cnt <= '0;
    end else begin
      state    <= state_nxt;
      park_cnt <= park_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_nxt    = state;
    park_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (!bus.obstacle && !spd_zero) state_nxt = START;
      end
      START: begin
        if (bus.obstacle)           state_nxt = EMERGENCY;
        else if (spd_zero)          state_nxt = IDLE;
        else if (spd >= START_SPD)  state_nxt = DRIVE;
      end
      DRIVE: begin
        if (bus.obstacle)           state_nxt = EMERGENCY;
        else if (spd_zero)          state_nxt = PARKING;
        else if (spd >= MOTION_SPD) state_nxt = MOTION;
      end
      MOTION: begin
        if (bus.obstacle)           state_nxt = EMERGENCY;
        else if (spd < DRIVE_SPD)   state_nxt = DRIVE;
      end
      EMERGENCY: begin
        if (!bus.obstacle)          state_nxt = spd_zero ? IDLE : START;
      end
      PARKING: begin
        // Counter tracks zero-speed cycles already spent here; leave on the last one.
        if (!spd_zero)                  state_nxt = START;
        else if (park_cnt == CNT_LAST)  state_nxt = IDLE;
        else                            park_cnt_nxt = park_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd            = state_cmd(state);
  assign bus.accelerate = cmd.accelerate;
  assign bus.brake      = cmd.brake;

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for the drive-mode controller: a mode-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_fsm;

  localparam int PARK_HOLD = 4;

  localparam int M_IDLE = 0, M_START = 1, M_DRIVE = 2, M_MOTION = 3, M_EMERG = 4, M_PARK = 5;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;

  fsm_if #(.SPEED_W(8)) bus ();

  fsm #(
    .SPEED_W(8), .START_SPD(10), .MOTION_SPD(30), .DRIVE_SPD(20), .PARK_HOLD(PARK_HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: acc/brk got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode plus number of zero-speed samples seen while parked.
  int mode = M_IDLE;
  int zero_seen = 0;

  function automatic void model_step(input int m, input int z, input int s, input bit obs,
                                     output int nm, output int nz);
    bit moving = (m == M_START) || (m == M_DRIVE) || (m == M_MOTION);
    nm = m;
    nz = 0;
    if (obs && moving)                      nm = M_EMERG;
    else if (m == M_IDLE)                   nm = (!obs && s > 0) ? M_START : M_IDLE;
    else if (m == M_START && s == 0)        nm = M_IDLE;
    else if (m == M_START && s >= 10)       nm = M_DRIVE;
    else if (m == M_DRIVE && s == 0)        nm = M_PARK;
    else if (m == M_DRIVE && s >= 30)       nm = M_MOTION;
    else if (m == M_MOTION && s < 20)       nm = M_DRIVE;
    else if (m == M_EMERG && !obs)          nm = (s == 0) ? M_IDLE : M_START;
    else if (m == M_PARK) begin
      if (s > 0) nm = M_START;
      else begin
        nz = z + 1;
        if (nz == PARK_HOLD) begin
          nm = M_IDLE;
          nz = 0;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    int nm, nz;
    if (reset) begin
      mode      <= M_IDLE;
      zero_seen <= 0;
    end else begin
      model_step(mode, zero_seen, int'(bus.speed), bus.obstacle, nm, nz);
      mode      <= nm;
      zero_seen <= nz;
    end
  end

  // Every cycle: outputs must match the model's mode, and never both be set.
  always @(negedge clk) begin
    logic [1:0] exp;
    if (chk_en) begin
      exp[1] = (mode == M_START) || (mode == M_DRIVE);
      exp[0] = (mode == M_EMERG) || (mode == M_PARK);
      check("model", {bus.accelerate, bus.brake}, exp);
      check("exclusive", {1'b0, bus.accelerate & bus.brake}, 2'b00);
    end
  end

  task automatic step(input int s, input bit obs, input bit rst = 1'b0);
    bus.speed    = 8'(s);
    bus.obstacle = obs;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.speed    = '0;
    bus.obstacle = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_idle", {bus.accelerate, bus.brake}, 2'b00);

    // Acceleration ladder and hysteresis
    step(0, 0);  check("idle_hold",   {bus.accelerate, bus.brake}, 2'b00);
    step(5, 0);  check("to_start",    {bus.accelerate, bus.brake}, 2'b10);
    step(12, 0); check("to_drive",    {bus.accelerate, bus.brake}, 2'b10);
    step(35, 0); check("to_motion",   {bus.accelerate, bus.brake}, 2'b00);
    step(25, 0); check("motion_hyst", {bus.accelerate, bus.brake}, 2'b00);
    step(15, 0); check("back_drive",  {bus.accelerate, bus.brake}, 2'b10);

    // Emergency held while obstacle, then release to START or IDLE
    step(15, 1); check("emerg",       {bus.accelerate, bus.brake}, 2'b01);
    step(0, 1);  check("emerg_hold",  {bus.accelerate, bus.brake}, 2'b01);
    step(9, 0);  check("emerg_start", {bus.accelerate, bus.brake}, 2'b10);
    step(9, 0);  check("start_hold9", {bus.accelerate, bus.brake}, 2'b10);
    step(10, 0); check("start_edge10",{bus.accelerate, bus.brake}, 2'b10);
    step(30, 0); check("drive_edge30",{bus.accelerate, bus.brake}, 2'b00);
    step(20, 0); check("motion_edge20",{bus.accelerate, bus.brake}, 2'b00);
    step(19, 0); check("motion_19",   {bus.accelerate, bus.brake}, 2'b10);
    step(0, 1);  check("obst_over_zero", {bus.accelerate, bus.brake}, 2'b01);
    step(0, 0);  check("emerg_idle",  {bus.accelerate, bus.brake}, 2'b00);

    // Full parking hold: PARKING for 4 zero-speed cycles, then IDLE
    step(5, 0); step(12, 0);
    step(0, 0);  check("to_park",     {bus.accelerate, bus.brake}, 2'b01);
    for (int i = 0; i < PARK_HOLD - 1; i++) begin
      step(0, 0); check("park_hold",  {bus.accelerate, bus.brake}, 2'b01);
    end
    step(0, 0);  check("park_idle",   {bus.accelerate, bus.brake}, 2'b00);

    // Aborted parking clears the counter: a fresh full hold is needed again
    step(5, 0); step(12, 0); step(0, 0);
    step(0, 0); step(0, 0);
    step(5, 0);  check("park_abort",  {bus.accelerate, bus.brake}, 2'b10);
    step(12, 0); step(0, 0);
    for (int i = 0; i < PARK_HOLD - 1; i++) begin
      step(0, 0); check("park_rehold", {bus.accelerate, bus.brake}, 2'b01);
    end
    step(0, 0);  check("park_reidle", {bus.accelerate, bus.brake}, 2'b00);
    check("model_pin_idle", {1'b0, mode == M_IDLE}, 2'b01);

    // Obstacle in IDLE blocks start
    step(25, 1); check("idle_obst",   {bus.accelerate, bus.brake}, 2'b00);
    step(25, 1); check("idle_obst2",  {bus.accelerate, bus.brake}, 2'b00);
    step(25, 0); check("idle_release",{bus.accelerate, bus.brake}, 2'b10);

    // Full-width speed and reset in the middle of MOTION
    step(255, 0); check("drive_255",  {bus.accelerate, bus.brake}, 2'b10);
    step(255, 0); check("motion_255", {bus.accelerate, bus.brake}, 2'b00);
    check("model_pin_motion", {1'b0, mode == M_MOTION}, 2'b01);
    step(35, 1, 1'b1); check("reset_mid", {bus.accelerate, bus.brake}, 2'b00);
    step(0, 0);  check("after_reset", {bus.accelerate, bus.brake}, 2'b00);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
